// File: rtl/serial_pattern_decoder.sv
// Serial pattern decoder: a WIDTH-bit pattern is loaded serially, then the
// incoming serial stream is compared against it once the window is full.
// Produces a registered match pulse, a sticky hit flag, a saturating hit
// counter and an optional one-shot mode that parks in HIT until rearm.
module serial_pattern_decoder #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             prgm_en,
   input  logic             prgm,
   input  logic             sig_en,
   input  logic             sig,
   input  logic             oneshot,
   input  logic             rearm,
   output logic             armed,
   output logic             match,
   output logic             hit,
   output logic [CNT_W-1:0] hit_count,
   output logic [WIDTH-1:0] pattern
);

   // Counters run 0..WIDTH, so they need room for the value WIDTH itself.
   localparam int FILL_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      EMPTY,
      LOADING,
      ARMED,
      HIT
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    window;
   logic [FILL_W-1:0]   prgm_cnt;
   logic [FILL_W-1:0]   sig_fill;

   logic [WIDTH-1:0]    candidate;
   logic                fill_ready;
   logic                match_now;
   logic                load_last;

   // Match and load-completion decode for the current edge.
   always_comb begin
      // The window as it will look after this edge's sig bit is shifted in.
      candidate  = {window[WIDTH-2:0], sig};
      // WIDTH-1 bits already held plus the incoming one make a full window.
      fill_ready = (sig_fill >= FILL_W'(WIDTH - 1));
      // A load edge always wins, so it suppresses any match.
      match_now  = (state == ARMED) && sig_en && !prgm_en && fill_ready &&
                   (candidate == pattern);
      load_last  = (state == LOADING) && (prgm_cnt == FILL_W'(WIDTH - 1));
   end

   // Pattern shift register; the first bit loaded ends up in the MSB.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pattern <= '0;
      end else if (prgm_en) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, whatever the statement order.
         pattern <= {pattern[WIDTH-2:0], prgm};
      end
   end

   // Signal window; shifts on every sig_en edge regardless of state.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         window <= '0;
      end else if (sig_en) begin
         window <= {window[WIDTH-2:0], sig};
      end
   end

   // Control FSM with load/fill counters and all registered outputs.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= EMPTY;
         prgm_cnt  <= '0;
         sig_fill  <= '0;
         armed     <= 1'b0;
         match     <= 1'b0;
         hit       <= 1'b0;
         hit_count <= '0;
      end else begin
         match <= match_now;

         // Fill saturates at WIDTH; entry to ARMED overrides this below.
         if (sig_en && (sig_fill != FILL_W'(WIDTH))) begin
            sig_fill <= sig_fill + 1'b1;
         end

         if (prgm_en) begin
            if (state != LOADING) begin
               // Start of a new load discards any previous hit history.
               state     <= LOADING;
               armed     <= 1'b0;
               prgm_cnt  <= FILL_W'(1);
               hit       <= 1'b0;
               hit_count <= '0;
            end else if (load_last) begin
               state    <= ARMED;
               armed    <= 1'b1;
               prgm_cnt <= '0;
               sig_fill <= '0;
            end else begin
               prgm_cnt <= prgm_cnt + 1'b1;
            end
         end else if (match_now) begin
            // A match outranks a coincident rearm, so hit stays set.
            hit <= 1'b1;
            if (hit_count != '1) begin
               hit_count <= hit_count + 1'b1;
            end
            if (oneshot) begin
               state <= HIT;
               armed <= 1'b0;
            end
         end else if (rearm) begin
            hit <= 1'b0;
            if (state == HIT) begin
               state    <= ARMED;
               armed    <= 1'b1;
               sig_fill <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_pattern_decoder.sv
// Directed bench for serial_pattern_decoder: reset, basic match, overlap,
// one-shot, reprogram, counter saturation and rearm/match priority.
// A second instance with CNT_W=2 shares all stimulus to expose saturation.
module tb_serial_pattern_decoder;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       prgm_en, prgm, sig_en, sig, oneshot, rearm;
   logic       armed, match, hit;
   logic [7:0] hit_count;
   logic [7:0] pattern;
   logic       armed2, match2, hit2;
   logic [1:0] hit_count2;
   logic [7:0] pattern2;

   int n_cmp  = 0;
   int n_fail = 0;

   serial_pattern_decoder #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .clr_n(clr_n), .prgm_en(prgm_en), .prgm(prgm),
      .sig_en(sig_en), .sig(sig), .oneshot(oneshot), .rearm(rearm),
      .armed(armed), .match(match), .hit(hit), .hit_count(hit_count),
      .pattern(pattern)
   );

   serial_pattern_decoder #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk(clk), .clr_n(clr_n), .prgm_en(prgm_en), .prgm(prgm),
      .sig_en(sig_en), .sig(sig), .oneshot(oneshot), .rearm(rearm),
      .armed(armed2), .match(match2), .hit(hit2), .hit_count(hit_count2),
      .pattern(pattern2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pe, p, se, s, rr;
      logic       a, m, h;
      logic [7:0] c;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t v(input logic pe, p, se, s, rr, a, m, h,
                              input logic [7:0] c);
      vec_t r;
      r.pe = pe; r.p = p; r.se = se; r.s = s; r.rr = rr;
      r.a = a; r.m = m; r.h = h; r.c = c;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and settle past the edge.
   task automatic step(input logic pe, p, se, s, rr);
      prgm_en = pe; prgm = p; sig_en = se; sig = s; rearm = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Stream n ones; match expected on sig edges 8 and later (1-based).
   task automatic stream_ones(input int n, input logic gaps, input string tag);
      for (int i = 1; i <= n; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         check($sformatf("%s match edge %0d", tag, i), 32'(match), 32'(i >= 8));
         if (gaps) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("%s gap match %0d", tag, i), 32'(match), 32'd0);
         end
      end
   endtask

   initial begin
      // Basic-match table: program A5 MSB first, then stream A5.
      tbl[0]  = v(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = v(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = v(1, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[6]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = v(1, 1, 0, 0, 0, 1, 0, 0, 0);
      tbl[8]  = v(0, 0, 1, 1, 0, 1, 0, 0, 0);
      tbl[9]  = v(0, 0, 1, 0, 0, 1, 0, 0, 0);
      tbl[10] = v(0, 0, 1, 1, 0, 1, 0, 0, 0);
      tbl[11] = v(0, 0, 1, 0, 0, 1, 0, 0, 0);
      tbl[12] = v(0, 0, 1, 0, 0, 1, 0, 0, 0);
      tbl[13] = v(0, 0, 1, 1, 0, 1, 0, 0, 0);
      tbl[14] = v(0, 0, 1, 0, 0, 1, 0, 0, 0);
      tbl[15] = v(0, 0, 1, 1, 0, 1, 1, 1, 1);
      tbl[16] = v(0, 0, 0, 0, 0, 1, 0, 1, 1);

      clr_n = 1'b0; prgm_en = 1'b0; prgm = 1'b0; sig_en = 1'b0;
      sig = 1'b0; oneshot = 1'b0; rearm = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("reset armed", 32'(armed), 32'd0);
      check("reset match", 32'(match), 32'd0);
      check("reset hit", 32'(hit), 32'd0);
      check("reset count", 32'(hit_count), 32'd0);
      check("reset pattern", 32'(pattern), 32'd0);
      clr_n = 1'b1;

      // Reset mid-load: three ones, then asynchronous clear.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("partial pattern", 32'(pattern), 32'h07);
      check("partial armed", 32'(armed), 32'd0);
      prgm_en = 1'b0;
      #2 clr_n = 1'b0;
      #1;
      check("async clr pattern", 32'(pattern), 32'd0);
      check("async clr armed", 32'(armed), 32'd0);
      @(posedge clk); #1;
      clr_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].pe, tbl[i].p, tbl[i].se, tbl[i].s, tbl[i].rr);
         check($sformatf("vec%0d armed", i), 32'(armed), 32'(tbl[i].a));
         check($sformatf("vec%0d match", i), 32'(match), 32'(tbl[i].m));
         check($sformatf("vec%0d hit", i), 32'(hit), 32'(tbl[i].h));
         check($sformatf("vec%0d count", i), 32'(hit_count), 32'(tbl[i].c));
      end
      check("pattern A5", 32'(pattern), 32'hA5);

      // Overlap in continuous mode, back-to-back then with sig_en gaps.
      load_byte(8'hFF);
      check("reload clears count", 32'(hit_count), 32'd0);
      check("reload clears hit", 32'(hit), 32'd0);
      stream_ones(10, 1'b0, "ovl");
      check("ovl count", 32'(hit_count), 32'd3);
      load_byte(8'hFF);
      stream_ones(10, 1'b1, "gap");
      check("gap count", 32'(hit_count), 32'd3);

      // One-shot: single match, park in HIT, then rearm and refill.
      load_byte(8'hFF);
      oneshot = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         check($sformatf("os match edge %0d", i), 32'(match), 32'(i == 8));
      end
      check("os count", 32'(hit_count), 32'd1);
      check("os in HIT armed", 32'(armed), 32'd0);
      check("os hit", 32'(hit), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rearm armed", 32'(armed), 32'd1);
      check("rearm hit", 32'(hit), 32'd0);
      check("rearm keeps count", 32'(hit_count), 32'd1);
      stream_ones(8, 1'b0, "rearm");
      check("rearm count", 32'(hit_count), 32'd2);
      oneshot = 1'b0;

      // Saturation: 5 matches; the CNT_W=2 copy stops at 3.
      load_byte(8'hFF);
      stream_ones(12, 1'b0, "sat");
      check("sat count w8", 32'(hit_count), 32'd5);
      check("sat count w2", 32'(hit_count2), 32'd3);

      // Rearm coincident with a match: hit stays, count advances.
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("prio match", 32'(match), 32'd1);
      check("prio hit", 32'(hit), 32'd1);
      check("prio count", 32'(hit_count), 32'd6);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rearm alone hit", 32'(hit), 32'd0);
      check("rearm alone count", 32'(hit_count), 32'd6);

      // Load edge on a would-be match: no match, history cleared.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("load beats match", 32'(match), 32'd0);
      check("load hit", 32'(hit), 32'd0);
      check("load count w8", 32'(hit_count), 32'd0);
      check("load count w2", 32'(hit_count2), 32'd0);
      check("load armed", 32'(armed), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
